// File: rtl/div.sv
// Iterative radix-2 restoring divider (signed/unsigned) for the EX stage.
// One quotient bit per cycle; the result is held until the consumer takes it; flush aborts.
module div #(
   parameter int WIDTH = 32
) (
   input  logic             div_clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] r,
   output logic             div_zero
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] ymag;
      logic             neg_q;
      logic             neg_r;
   } op_t;

   state_t           state, state_nxt;
   op_t              op;
   logic [WIDTH-1:0] rem, quo, rem_nxt, quo_nxt, xmag, ymag_in;
   logic [WIDTH:0]   sh, trial;
   logic [CW-1:0]    cnt;
   logic             accept, last, ge;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready && !flush;
   assign last      = (cnt == CW'(WIDTH - 1));

   assign xmag    = (div_signed && x[WIDTH-1]) ? -x : x;
   assign ymag_in = (div_signed && y[WIDTH-1]) ? -y : y;

   // Shifted partial remainder is below 2*|y|, so the trial MSB alone is the sign.
   assign sh      = {rem, quo[WIDTH-1]};
   assign trial   = sh - {1'b0, op.ymag};
   assign ge      = ~trial[WIDTH];
   assign rem_nxt = ge ? trial[WIDTH-1:0] : sh[WIDTH-1:0];
   assign quo_nxt = {quo[WIDTH-2:0], ge};

   always_ff @(posedge div_clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (in_valid) state_nxt = (y == '0) ? DONE : CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge div_clk or negedge resetn) begin
      if (!resetn) begin
         op       <= '0;
         rem      <= '0;
         quo      <= '0;
         cnt      <= '0;
         s        <= '0;
         r        <= '0;
         div_zero <= 1'b0;
      end else if (accept) begin
         if (y == '0) begin
            s        <= '1;
            r        <= x;
            div_zero <= 1'b1;
         end else begin
            op.ymag  <= ymag_in;
            op.neg_q <= div_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
            op.neg_r <= div_signed && x[WIDTH-1];
            quo      <= xmag;
            rem      <= '0;
            cnt      <= '0;
         end
      end else if (state == CALC && !flush) begin
         quo <= quo_nxt;
         rem <= rem_nxt;
         cnt <= cnt + 1'b1;
         if (last) begin
            s        <= op.neg_q ? -quo_nxt : quo_nxt;
            r        <= op.neg_r ? -rem_nxt : rem_nxt;
            div_zero <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_div.sv
// Directed vectors plus a randomized reference-model run for the iterative divider.
module tb_div;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        div_signed = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] x = '0, y = '0;
   logic        in_ready, out_valid, div_zero;
   logic [31:0] s, r;
   int          n_tests = 0, n_fail = 0;

   div #(.WIDTH(32)) dut (
      .div_clk(clk), .resetn(resetn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .div_signed(div_signed),
      .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .r(r), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present operands, check acceptance, scramble inputs, then wait (bounded) for out_valid.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                           output int lat);
      @(negedge clk);
      x = a; y = b; div_signed = sg; in_valid = 1'b1;
      chk("accept_ready", in_ready, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0; x = $urandom; y = $urandom; div_signed = 1'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 80);
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic do_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input logic [31:0] es, input logic [31:0] er,
                         input logic ez);
      int lat;
      start_op(a, b, sg, lat);
      chk({tag, "_lat"}, lat, (b == 0) ? 1 : 33);
      chk({tag, "_s"}, s, es);
      chk({tag, "_r"}, r, er);
      chk({tag, "_dz"}, div_zero, ez);
      take();
   endtask

   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                   output logic [31:0] q, output logic [31:0] rm,
                                   output logic z);
      int sa, sb;
      sa = a; sb = b; z = 1'b0;
      if (b == 0) begin
         q = '1; rm = a; z = 1'b1;
      end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; rm = '0;
      end else if (sg) begin
         q = 32'(sa / sb); rm = 32'(sa % sb);
      end else begin
         q = a / b; rm = a % b;
      end
   endfunction

   initial begin
      logic [31:0] hs, hr, ea, eb, es, er;
      logic        ez, esg;
      int          lat, hold;

      #12;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_s", s, 32'h0);
      chk("rst_r", r, 32'h0);
      chk("rst_dz", div_zero, 1'b0);
      @(negedge clk) resetn = 1'b1;

      do_vec("u100_7",  32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0);
      do_vec("sm7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
      do_vec("s7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0);
      do_vec("s_ovf",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0);
      do_vec("u_max_1", 32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0);
      do_vec("u_max_m1",32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0);
      do_vec("dz_u",    32'h1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234,       1'b1);
      do_vec("dz_s",    32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1);

      // Backpressure: result must hold while out_ready is low.
      start_op(32'd1000, 32'd33, 1'b0, lat);
      chk("bp_lat", lat, 33);
      for (int i = 0; i < 5; i++) begin
         chk("bp_s", s, 32'd30);
         chk("bp_r", r, 32'd10);
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_out_valid", out_valid, 1'b1);
         @(negedge clk);
      end
      take();
      do_vec("b2b", 32'd81, 32'd9, 1'b0, 32'd9, 32'd0, 1'b0);

      // Flush at cnt==10: back to IDLE, outputs keep the previous result.
      @(negedge clk);
      x = 32'd5000; y = 32'd3; div_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("fl_out_valid", out_valid, 1'b0);
      chk("fl_in_ready", in_ready, 1'b1);
      chk("fl_s_kept", s, 32'd9);
      chk("fl_r_kept", r, 32'd0);

      // Flush coincident with a request in IDLE: request is dropped.
      @(negedge clk);
      x = 32'd5; y = 32'd0; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("fl_req_drop_rdy", in_ready, 1'b1);
      chk("fl_req_drop_ov", out_valid, 1'b0);
      chk("fl_req_drop_dz", div_zero, 1'b0);

      // Asynchronous reset at cnt==20 discards the operation.
      x = 32'd5000; y = 32'd3; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("ar_in_ready", in_ready, 1'b1);
      chk("ar_out_valid", out_valid, 1'b0);
      chk("ar_s", s, 32'h0);
      chk("ar_r", r, 32'h0);
      @(negedge clk) resetn = 1'b1;
      do_vec("after_rst", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0);

      // Random run with reference model and random out_ready delay.
      for (int n = 0; n < 300; n++) begin
         ea = $urandom; eb = $urandom; esg = 1'($urandom);
         case ($urandom_range(0, 7))
            0: eb = 32'd0;
            1: eb = $urandom_range(1, 15);
            2: begin ea = 32'h8000_0000; eb = 32'hFFFF_FFFF; end
            3: eb = eb >> $urandom_range(1, 31);
            default: ;
         endcase
         ref_div(ea, eb, esg, es, er, ez);
         hold = $urandom_range(0, 3);
         start_op(ea, eb, esg, lat);
         chk("rnd_lat", lat, (eb == 0) ? 1 : 33);
         hs = s; hr = r;
         repeat (hold) @(negedge clk);
         chk("rnd_s", hs, es);
         chk("rnd_r", hr, er);
         chk("rnd_dz", div_zero, ez);
         chk("rnd_hold_s", s, hs);
         take();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
